// File: rtl/wb_pkg.sv
// Shared constants and state encoding for the layer-b weight store (loader and reader).
// The optional checksum stage is built when WB_LOADER_CHECKSUM_EN is defined.
package wb_pkg;

    localparam int M      = 8;
    localparam int TAPS   = 18;
    localparam int NFILT  = 8;
    localparam int AW     = 8;
    localparam int WORD_W = M * TAPS;
    localparam int TAP_CW = $clog2(TAPS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4
    } wb_state_e;

    function automatic logic is_last_filt(input logic [AW-1:0] filt);
        return filt == AW'(NFILT - 1);
    endfunction

endpackage

// File: rtl/wb_tap_packer.sv
// Packs TAPS bytes into one filter word, first byte in the MSB lane.
// Raises word_full on the accept that completes a word.
module wb_tap_packer
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [M-1:0]      data,
    output logic [WORD_W-1:0] word_nxt,
    output logic              word_full
);

    // Only the earlier TAPS-1 bytes need storing; the last byte comes straight from data.
    logic [WORD_W-M-1:0] shreg;
    logic [TAP_CW-1:0]   tap_cnt;

    assign word_nxt  = {shreg, data};
    assign word_full = accept && (tap_cnt == TAP_CW'(TAPS - 1));

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shreg   <= '0;
            tap_cnt <= '0;
        end else if (clear) begin
            tap_cnt <= '0;
        end else if (accept) begin
            shreg   <= word_nxt[WORD_W-M-1:0];
            tap_cnt <= word_full ? '0 : tap_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_loader_b.sv
// Layer-b weight loader: byte stream -> NFILT packed filter words at RAM addresses 0..NFILT-1.
// Define WB_LOADER_CHECKSUM_EN to add the trailing checksum byte check (CHK state, sticky err).
module wb_loader_b
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [M-1:0]      s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              load_done,
    output logic              err
);

    wb_state_e         state, state_nxt;
    logic [AW-1:0]     filt_cnt;
    logic              accept;
    logic              tap_accept;
    logic              clear;
    logic              word_full;
    logic [WORD_W-1:0] word_nxt;

    assign accept     = s_valid && s_ready;
    assign tap_accept = accept && (state == ST_LOAD);
    assign clear      = (state == ST_IDLE) && start;

    wb_tap_packer u_packer (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .clear     (clear),
        .accept    (tap_accept),
        .data      (s_data),
        .word_nxt  (word_nxt),
        .word_full (word_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  if (word_full) state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (is_last_filt(filt_cnt))
`ifdef WB_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_DONE;
`endif
                else
                    state_nxt = ST_LOAD;
            end
            ST_CHK:   if (accept) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            filt_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            s_ready   <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHK);
            busy      <= (state_nxt != ST_IDLE);
            load_done <= (state_nxt == ST_DONE);
            wr_en     <= word_full;
            if (word_full) begin
                wr_addr <= filt_cnt;
                wr_data <= word_nxt;
            end
            if (clear)
                filt_cnt <= '0;
            else if ((state == ST_WRITE) && !is_last_filt(filt_cnt))
                filt_cnt <= filt_cnt + 1'b1;
        end
    end

`ifdef WB_LOADER_CHECKSUM_EN
    logic [M-1:0] csum;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (clear) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            if (tap_accept)
                csum <= csum + s_data;
            if ((state == ST_CHK) && accept && (s_data != csum))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
